// File: rtl/axi_wr_pkg.sv
// Shared definitions for the AXI burst write controller: FSM encoding,
// AXI response/burst constants and a constant-evaluable ceil(log2).
package axi_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_wr_beat_cnt.sv
// Counts accepted W beats within a burst and flags the final beat so the
// controller can drive WLAST; wraps to zero after the last beat.
module axi_wr_beat_cnt #(
  parameter int BURST_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic beat,
  output logic last
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (beat) begin
      cnt <= last ? 8'd0 : cnt + 8'd1;
    end
  end

  assign last = (cnt == LAST_BEAT);

endmodule

// File: rtl/axi_burst_wr_ctrl.sv
// Streams a first-word-fall-through FIFO into fixed-length AXI INCR write
// bursts over a circular region starting at a latched base address.
module axi_burst_wr_ctrl
  import axi_wr_pkg::*;
#(
  parameter int          C_M_AXI_ADDR_WIDTH = 28,
  parameter int          C_M_AXI_DATA_WIDTH = 16,
  parameter int          C_M_AXI_BURST_LEN  = 16,
  parameter int unsigned C_FRAME_BYTES      = 32'h0010_0000
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            CTRL_START,
  input  logic                            CTRL_STOP,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CTRL_AWADDR,
  output logic                            CTRL_BUSY,
  output logic                            CTRL_ERR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   FIFO_AXI_DATA,
  input  logic [8:0]                      FIFO_RD_CNT,
  output logic                            FIFO_RD_EN,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  localparam int BURST_BYTES = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STEP  = C_M_AXI_ADDR_WIDTH'(BURST_BYTES);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] FRAME_SPAN = C_M_AXI_ADDR_WIDTH'(C_FRAME_BYTES);

  wr_state_t state, state_next;

  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_next;
  logic                          stop_pend;
  logic                          err_q;
  logic                          last_beat;
  logic                          start_ok;
  logic                          stop_req;
  logic                          fifo_ready;
  logic                          b_done;

  assign start_ok   = CTRL_START && (state == ST_IDLE);
  assign stop_req   = stop_pend || CTRL_STOP;
  assign fifo_ready = FIFO_RD_CNT >= 9'(C_M_AXI_BURST_LEN);
  assign b_done     = (state == ST_RESP) && M_AXI_BVALID;
  assign addr_next  = awaddr_q + ADDR_STEP;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (CTRL_START) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (stop_req)        state_next = ST_IDLE;
        else if (fifo_ready) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) state_next = ST_DATA;
      end
      ST_DATA: begin
        M_AXI_WVALID = 1'b1;
        if (M_AXI_WREADY && last_beat) state_next = ST_RESP;
      end
      ST_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_next = ST_WAIT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A stop raised alongside an accepted start is remembered so the first
  // WAIT visit returns straight to IDLE without issuing a burst.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      base_addr <= '0;
      awaddr_q  <= '0;
      stop_pend <= 1'b0;
      err_q     <= 1'b0;
    end else if (start_ok) begin
      base_addr <= CTRL_AWADDR;
      awaddr_q  <= CTRL_AWADDR;
      stop_pend <= CTRL_STOP;
      err_q     <= 1'b0;
    end else begin
      if ((state == ST_WAIT) && stop_req) begin
        stop_pend <= 1'b0;
      end else if (CTRL_STOP && (state != ST_IDLE)) begin
        stop_pend <= 1'b1;
      end
      if (b_done) begin
        awaddr_q <= (addr_next == base_addr + FRAME_SPAN) ? base_addr : addr_next;
        if (M_AXI_BRESP != RESP_OKAY) err_q <= 1'b1;
      end
    end
  end

  axi_wr_beat_cnt #(
    .BURST_LEN(C_M_AXI_BURST_LEN)
  ) u_beat_cnt (
    .clk (M_AXI_ACLK),
    .rst (M_AXI_ARESET),
    .beat(FIFO_RD_EN),
    .last(last_beat)
  );

  assign FIFO_RD_EN    = M_AXI_WVALID && M_AXI_WREADY;
  assign M_AXI_WLAST   = M_AXI_WVALID && last_beat;
  assign M_AXI_WDATA   = FIFO_AXI_DATA;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_AWSIZE  = 3'(clog2(C_M_AXI_DATA_WIDTH / 8));
  assign M_AXI_AWBURST = BURST_INCR;
  assign CTRL_BUSY     = (state != ST_IDLE);
  assign CTRL_ERR      = err_q;

endmodule

// File: tb/tb_axi_burst_wr_ctrl.sv
// Bench for axi_burst_wr_ctrl: a transaction-level model predicts every
// output cycle by cycle under directed and randomized AXI/FIFO behaviour.
module tb_axi_burst_wr_ctrl;

  localparam int BL    = 16;
  localparam int BYTES = 32;
  localparam int FRAME = 64;
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_ADDR = 2, PH_DATA = 3, PH_RESP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, stop_a, busy_a, err_a, rd_en_a;
  logic [27:0] addr_a, awaddr_a;
  logic [15:0] fifo_data, wdata_a;
  logic [8:0]  fifo_cnt;
  logic [7:0]  awlen_a;
  logic [2:0]  awsize_a;
  logic [1:0]  awburst_a, wstrb_a, bresp_a;
  logic        awvalid_a, awready_a, wlast_a, wvalid_a, wready_a, bvalid_a, bready_a;

  axi_burst_wr_ctrl #(
    .C_M_AXI_ADDR_WIDTH(28), .C_M_AXI_DATA_WIDTH(16),
    .C_M_AXI_BURST_LEN(16), .C_FRAME_BYTES(64)
  ) dut_a (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst_a),
    .CTRL_START(start_a), .CTRL_STOP(stop_a), .CTRL_AWADDR(addr_a),
    .CTRL_BUSY(busy_a), .CTRL_ERR(err_a),
    .FIFO_AXI_DATA(fifo_data), .FIFO_RD_CNT(fifo_cnt), .FIFO_RD_EN(rd_en_a),
    .M_AXI_AWADDR(awaddr_a), .M_AXI_AWLEN(awlen_a), .M_AXI_AWSIZE(awsize_a),
    .M_AXI_AWBURST(awburst_a), .M_AXI_AWVALID(awvalid_a), .M_AXI_AWREADY(awready_a),
    .M_AXI_WDATA(wdata_a), .M_AXI_WSTRB(wstrb_a), .M_AXI_WLAST(wlast_a),
    .M_AXI_WVALID(wvalid_a), .M_AXI_WREADY(wready_a),
    .M_AXI_BRESP(bresp_a), .M_AXI_BVALID(bvalid_a), .M_AXI_BREADY(bready_a)
  );

  // Wide-bus, single-beat instance with a small wrap region.
  logic        rst_b, start_b, busy_b, err_b, rd_en_b;
  logic [27:0] awaddr_b;
  logic [63:0] wdata_b;
  logic [7:0]  awlen_b, wstrb_b;
  logic [2:0]  awsize_b;
  logic [1:0]  awburst_b;
  logic        awvalid_b, wlast_b, wvalid_b, bready_b;

  axi_burst_wr_ctrl #(
    .C_M_AXI_ADDR_WIDTH(28), .C_M_AXI_DATA_WIDTH(64),
    .C_M_AXI_BURST_LEN(1), .C_FRAME_BYTES(64)
  ) dut_b (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst_b),
    .CTRL_START(start_b), .CTRL_STOP(1'b0), .CTRL_AWADDR(28'h200),
    .CTRL_BUSY(busy_b), .CTRL_ERR(err_b),
    .FIFO_AXI_DATA(64'hDEAD_BEEF_0123_4567), .FIFO_RD_CNT(9'd5), .FIFO_RD_EN(rd_en_b),
    .M_AXI_AWADDR(awaddr_b), .M_AXI_AWLEN(awlen_b), .M_AXI_AWSIZE(awsize_b),
    .M_AXI_AWBURST(awburst_b), .M_AXI_AWVALID(awvalid_b), .M_AXI_AWREADY(1'b1),
    .M_AXI_WDATA(wdata_b), .M_AXI_WSTRB(wstrb_b), .M_AXI_WLAST(wlast_b),
    .M_AXI_WVALID(wvalid_b), .M_AXI_WREADY(1'b1),
    .M_AXI_BRESP(2'b00), .M_AXI_BVALID(1'b1), .M_AXI_BREADY(bready_b)
  );

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;

  logic        drv_rst, drv_start, drv_stop, drv_wready, drv_awready, drv_bvalid, rand_mode;
  logic [27:0] drv_addr;
  logic [1:0]  drv_bresp;
  logic [15:0] next_word;

  logic [15:0] fifo_q[$];
  logic [15:0] hist[$];
  logic [27:0] aw_log[$];
  logic [27:0] b_aw_log[$];
  logic [15:0] w_log[$];
  logic        wl_log[$];
  int          aw_high;

  int          m_valid, m_phase, m_beat, m_idx, m_data_idx, m_bursts;
  logic        m_err, m_stop;
  logic [27:0] m_base, m_awaddr;

  logic        s_busy, s_err, s_awvalid, s_wvalid, s_wlast, s_bready, s_rd_en;
  logic [27:0] s_awaddr;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, gcyc);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_word);
      hist.push_back(next_word);
      next_word++;
    end
  endtask

  task automatic clear_logs();
    aw_log.delete();
    w_log.delete();
    wl_log.delete();
  endtask

  // Expected outputs follow from the transaction view: where the burst is,
  // which beat is next, and which pushed word that beat must carry.
  task automatic compare_model();
    logic [15:0] exp_data;
    if (m_valid == 0) return;
    check_output("busy",    busy_a,    m_phase != PH_IDLE);
    check_output("awvalid", awvalid_a, m_phase == PH_ADDR);
    check_output("awaddr",  awaddr_a,  m_awaddr);
    check_output("wvalid",  wvalid_a,  m_phase == PH_DATA);
    check_output("wlast",   wlast_a,   (m_phase == PH_DATA) && (m_beat == BL - 1));
    check_output("bready",  bready_a,  m_phase == PH_RESP);
    check_output("rd_en",   rd_en_a,   (m_phase == PH_DATA) && drv_wready);
    check_output("err",     err_a,     m_err);
    if (m_phase == PH_DATA) begin
      exp_data = (m_data_idx < hist.size()) ? hist[m_data_idx] : 16'h0;
      check_output("wdata", wdata_a, exp_data);
    end
  endtask

  task automatic model_step();
    if (m_valid == 0 && !drv_rst) return;
    if (m_phase == PH_DATA && drv_wready) m_data_idx++;
    if (drv_rst) begin
      m_valid = 1; m_phase = PH_IDLE; m_beat = 0; m_err = 0; m_stop = 0;
      m_awaddr = '0; m_base = '0; m_idx = 0;
      return;
    end
    if (m_phase != PH_IDLE && m_phase != PH_WAIT && drv_stop) m_stop = 1;
    case (m_phase)
      PH_IDLE: if (drv_start) begin
        m_phase = PH_WAIT; m_base = drv_addr; m_awaddr = drv_addr;
        m_idx = 0; m_err = 0; m_stop = drv_stop;
      end
      PH_WAIT: begin
        if (m_stop || drv_stop) begin m_phase = PH_IDLE; m_stop = 0; end
        else if (int'(fifo_cnt) >= BL) m_phase = PH_ADDR;
      end
      PH_ADDR: if (drv_awready) m_phase = PH_DATA;
      PH_DATA: if (drv_wready) begin
        if (m_beat == BL - 1) begin m_beat = 0; m_phase = PH_RESP; end
        else m_beat++;
      end
      PH_RESP: if (drv_bvalid) begin
        if (drv_bresp != 2'b00) m_err = 1;
        m_idx++;
        m_awaddr = 28'(int'(m_base) + (m_idx * BYTES) % FRAME);
        m_bursts++;
        m_phase = PH_WAIT;
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  task automatic apply_stimulus();
    if (rand_mode) begin
      drv_wready  = 1'($urandom_range(0, 1));
      drv_awready = ($urandom_range(0, 2) == 0);
      drv_bvalid  = 1'($urandom_range(0, 1));
      drv_bresp   = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
      if ($urandom_range(0, 59) == 0) drv_stop = 1'b1;
      if ($urandom_range(0, 19) == 0) begin
        drv_start = 1'b1;
        drv_addr  = 28'($urandom_range(0, 1023) * BYTES);
      end
      if (fifo_q.size() < 24 && $urandom_range(0, 1) == 1) push_words(4);
    end
    rst_a     = drv_rst;
    start_a   = drv_start;
    stop_a    = drv_stop;
    addr_a    = drv_addr;
    wready_a  = drv_wready;
    awready_a = drv_awready;
    bvalid_a  = drv_bvalid;
    bresp_a   = drv_bresp;
    fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
    fifo_cnt  = (fifo_q.size() > 511) ? 9'd511 : 9'(fifo_q.size());
    rst_b     = (gcyc < 2);
    start_b   = (gcyc == 3);
  endtask

  task automatic cycle();
    @(negedge clk);
    apply_stimulus();
    #1;
    s_busy = busy_a; s_err = err_a; s_awvalid = awvalid_a; s_wvalid = wvalid_a;
    s_wlast = wlast_a; s_bready = bready_a; s_rd_en = rd_en_a; s_awaddr = awaddr_a;
    compare_model();
    if (awvalid_a) aw_high++;
    if (awvalid_a && drv_awready) aw_log.push_back(awaddr_a);
    if (wvalid_a && drv_wready) begin
      w_log.push_back(wdata_a);
      wl_log.push_back(wlast_a);
    end
    if (awvalid_b) b_aw_log.push_back(awaddr_b);
    if (wvalid_b) check_output("b_wlast", wlast_b, 1);
    model_step();
    if (rd_en_a && fifo_q.size() > 0) void'(fifo_q.pop_front());
    gcyc++;
    drv_start = 1'b0;
    drv_stop  = 1'b0;
    drv_rst   = 1'b0;
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("[TB] FAIL timeout %s: model phase %0d beat %0d", what, m_phase, m_beat);
  endtask

  task automatic wait_phase(input int ph, input string what);
    for (int i = 0; i < 400; i++) begin
      if (m_phase == ph) return;
      cycle();
    end
    timeout(what);
  endtask

  task automatic wait_bursts(input int n, input string what);
    int target;
    target = m_bursts + n;
    for (int i = 0; i < 60 * n + 200; i++) begin
      if (m_bursts >= target) return;
      cycle();
    end
    timeout(what);
  endtask

  task automatic wait_beat(input int b, input string what);
    for (int i = 0; i < 400; i++) begin
      if (m_phase == PH_DATA && m_beat == b) return;
      cycle();
    end
    timeout(what);
  endtask

  function automatic int count_wlast();
    int n;
    n = 0;
    foreach (wl_log[i]) if (wl_log[i]) n++;
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drv_rst = 1'b1; drv_start = 1'b0; drv_stop = 1'b0; drv_addr = '0;
    drv_wready = 1'b1; drv_awready = 1'b1; drv_bvalid = 1'b1; drv_bresp = 2'b00;
    rand_mode = 1'b0; next_word = 16'h0001; aw_high = 0;
    m_valid = 0; m_phase = PH_IDLE; m_beat = 0; m_idx = 0; m_data_idx = 0; m_bursts = 0;
    m_err = 0; m_stop = 0; m_base = '0; m_awaddr = '0;
    rst_a = 1'b1; start_a = 1'b0; stop_a = 1'b0; addr_a = '0; wready_a = 1'b1;
    awready_a = 1'b1; bvalid_a = 1'b1; bresp_a = 2'b00; fifo_data = '0; fifo_cnt = '0;
    rst_b = 1'b1; start_b = 1'b0;

    drv_rst = 1'b1; cycle();
    drv_rst = 1'b1; cycle();
    cycle();
    check_output("reset_busy", s_busy, 0);
    check_output("reset_awaddr", s_awaddr, 0);

    // Single burst of words 1..16 to 0x1000 with all readies high.
    clear_logs();
    push_words(16);
    drv_addr = 28'h000_1000; drv_start = 1'b1; cycle();
    wait_bursts(1, "first_burst");
    cycle();
    check_output("first_aw_count", aw_log.size(), 1);
    check_output("first_aw_addr", aw_log[0], 28'h000_1000);
    check_output("first_beat_count", w_log.size(), 16);
    check_output("first_beat_data", w_log[0], 16'h0001);
    check_output("last_beat_data", w_log[15], 16'h0010);
    check_output("wlast_on_16th", wl_log[15], 1);
    check_output("wlast_count", count_wlast(), 1);
    check_output("busy_in_wait", s_busy, 1);
    drv_stop = 1'b1; cycle();
    cycle();
    check_output("idle_after_stop", s_busy, 0);

    // Region wrap: 64-byte frame at 0x100 with 32-byte bursts.
    clear_logs();
    push_words(64);
    drv_addr = 28'h100; drv_start = 1'b1; cycle();
    wait_bursts(4, "wrap_bursts");
    check_output("wrap_addr0", aw_log[0], 28'h100);
    check_output("wrap_addr1", aw_log[1], 28'h120);
    check_output("wrap_addr2", aw_log[2], 28'h100);
    check_output("wrap_addr3", aw_log[3], 28'h120);

    // AWREADY withheld for ten cycles while AWADDR must hold.
    drv_awready = 1'b0;
    push_words(16);
    wait_phase(PH_ADDR, "enter_addr");
    aw_high = 0;
    repeat (10) cycle();
    drv_awready = 1'b1;
    cycle();
    check_output("awvalid_held_cycles", aw_high, 11);
    check_output("delayed_aw_addr", aw_log[4], 28'h100);
    wait_bursts(1, "delayed_burst");

    rand_mode = 1'b1;
    repeat (1500) cycle();
    rand_mode = 1'b0;
    drv_wready = 1'b1; drv_awready = 1'b1; drv_bvalid = 1'b1; drv_bresp = 2'b00;

    // Error response on the first burst is sticky until the next start.
    drv_stop = 1'b1; cycle();
    wait_phase(PH_IDLE, "idle_before_err");
    cycle();
    clear_logs();
    drv_bresp = 2'b10;
    push_words(32);
    drv_addr = 28'h40; drv_start = 1'b1; cycle();
    wait_bursts(1, "err_burst");
    drv_bresp = 2'b00;
    cycle();
    check_output("err_after_bresp", s_err, 1);
    wait_bursts(1, "second_burst");
    cycle();
    check_output("err_sticky", s_err, 1);
    check_output("second_burst_ran", aw_log.size(), 2);
    drv_stop = 1'b1; cycle();
    wait_phase(PH_IDLE, "idle_after_err");
    drv_addr = 28'h40; drv_start = 1'b1; cycle();
    cycle();
    check_output("err_cleared_by_start", s_err, 0);

    // Stop requested on beat 5 still completes the whole burst.
    clear_logs();
    push_words(16);
    wait_beat(5, "stop_beat");
    drv_stop = 1'b1; cycle();
    wait_phase(PH_IDLE, "idle_after_stop_beat");
    check_output("stop_burst_beats", w_log.size(), 16);
    check_output("stop_burst_wlast", count_wlast(), 1);
    cycle();
    check_output("stop_busy_low", s_busy, 0);

    // Reset on beat 5 abandons the burst immediately.
    push_words(16);
    drv_addr = 28'h80; drv_start = 1'b1; cycle();
    wait_beat(5, "reset_beat");
    drv_rst = 1'b1; cycle();
    cycle();
    check_output("midrst_busy", s_busy, 0);
    check_output("midrst_awvalid", s_awvalid, 0);
    check_output("midrst_wvalid", s_wvalid, 0);
    check_output("midrst_wlast", s_wlast, 0);
    check_output("midrst_bready", s_bready, 0);
    check_output("midrst_rd_en", s_rd_en, 0);
    check_output("midrst_awaddr", s_awaddr, 0);
    check_output("midrst_err", s_err, 0);

    check_output("awlen", awlen_a, 8'd15);
    check_output("awsize", awsize_a, 3'd1);
    check_output("awburst", awburst_a, 2'b01);
    check_output("wstrb", wstrb_a, 2'b11);
    check_output("b_awsize", awsize_b, 3'd3);
    check_output("b_awlen", awlen_b, 8'd0);
    check_output("b_wstrb", wstrb_b, 8'hFF);
    check_output("b_addr0", b_aw_log[0], 28'h200);
    check_output("b_addr1", b_aw_log[1], 28'h208);
    check_output("b_addr2", b_aw_log[2], 28'h210);
    check_output("b_addr_wrap", b_aw_log[8], 28'h200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
